// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_SUM,
    S_DONE,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/uart_program_loader_byte_packer.sv
// Packs a byte stream big-endian into 32-bit words; shared by header and payload.
// o_word / o_word_ready are combinational so the consumer can register the word
// on the same edge that samples its final byte.
module byte_packer
  import loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [7:0]        i_data,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_ready
);

  localparam int unsigned   IdxW    = $clog2(BYTES_PER_WORD);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES_PER_WORD - 1);

  logic [IdxW-1:0]   r_idx;
  logic [WORD_W-1:0] r_sh;

  assign o_word       = {r_sh[WORD_W-9:0], i_data};
  assign o_word_ready = i_valid && !i_clear && (r_idx == LastIdx);

  // Byte index and shift register; clear drops any partial word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= '0;
      r_sh  <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
      r_sh  <= '0;
    end else if (i_valid) begin
      r_idx <= r_idx + IdxW'(1);
      r_sh  <= o_word;
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: parses a length-prefixed image from the UART byte stream and
// writes big-endian packed words into instruction memory.
// Optional checksum byte after the payload: define LOADER_CHECKSUM_EN.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 2 ** ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_restart,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_len,
  output logic              o_err_sum,
  output logic [31:0]       o_word_cnt
);

`ifdef LOADER_CHECKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  loader_state_t     r_state;
  logic [31:0]       r_ptr;
  logic [31:0]       r_word_cnt;
  logic [7:0]        r_sum;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err_len;
  logic              r_err_sum;

  logic              w_pk_valid;
  logic [31:0]       w_word;
  logic              w_word_ready;

  // Only header and payload bytes go through the packer; the checksum byte is used raw.
  assign w_pk_valid = i_rx_valid && ((r_state == S_LEN) || (r_state == S_DATA));

  byte_packer u_packer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (i_restart),
    .i_valid      (w_pk_valid),
    .i_data       (i_rx_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  // Loader FSM with write pointer, checksum and sticky status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_LEN;
      r_ptr        <= '0;
      r_word_cnt   <= '0;
      r_sum        <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err_len    <= 1'b0;
      r_err_sum    <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      if (i_restart) begin
        // Restart wins over a coincident byte, which is dropped.
        r_state    <= S_LEN;
        r_ptr      <= '0;
        r_word_cnt <= '0;
        r_sum      <= '0;
        r_busy     <= 1'b0;
        r_done     <= 1'b0;
        r_err_len  <= 1'b0;
        r_err_sum  <= 1'b0;
      end else begin
        case (r_state)
          S_LEN: begin
            if (i_rx_valid) begin
              r_busy <= 1'b1;
              if (w_word_ready) begin
                r_word_cnt <= w_word;
                if (w_word == 32'd0) begin
                  if (ChkEn) begin
                    r_state <= S_SUM;
                  end else begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                  end
                end else if (w_word > MAX_WORDS) begin
                  r_state   <= S_ERR;
                  r_err_len <= 1'b1;
                  r_busy    <= 1'b0;
                end else begin
                  r_state <= S_DATA;
                end
              end
            end
          end
          S_DATA: begin
            if (i_rx_valid) begin
              r_sum <= r_sum ^ i_rx_data;
            end
            if (w_word_ready) begin
              r_imem_we    <= 1'b1;
              r_imem_wdata <= w_word;
              r_imem_addr  <= BaseAddr + r_ptr[ADDR_W-1:0];
              r_ptr        <= r_ptr + 32'd1;
              if (r_ptr == r_word_cnt - 32'd1) begin
                if (ChkEn) begin
                  r_state <= S_SUM;
                end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                end
              end
            end
          end
          S_SUM: begin
            if (i_rx_valid) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_err_sum <= (i_rx_data != r_sum);
            end
          end
          S_DONE, S_ERR: begin
            // Terminal until restart; incoming bytes are ignored.
          end
          default: r_state <= S_ERR;
        endcase
      end
    end
  end

  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err_len    = r_err_len;
  assign o_err_sum    = r_err_sum & ChkEn;
  assign o_word_cnt   = r_word_cnt;

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
Sits directly downstream of the UART byte receiver and consumes its 8-bit byte / one-cycle valid pulse stream. Parses a length-prefixed program image, packs bytes big-endian into 32-bit words, and writes them sequentially into instruction memory. Signals completion so the core can leave boot mode and start fetching.

Parameters:
ADDR_W, 14, instruction memory word-address width.
BASE_ADDR, 0, word address of the first payload word.
MAX_WORDS, 2**ADDR_W, largest accepted word count; larger headers are rejected.

Ports:
CLK  in  1  system clock.
RST_N  in  1  reset, asynchronous, active-low.
rx_data  in  8  received byte; sampled only when rx_valid=1.
rx_valid  in  1  one-cycle strobe per received byte.
restart  in  1  one-cycle pulse; re-arms the loader for a new image.
imem_we  out  1  one-cycle instruction memory write enable.
imem_addr  out  ADDR_W  write word address.
imem_wdata  out  32  write data.
busy  out  1  high once the first header byte has arrived, until done/err.
done  out  1  sticky: image fully loaded.
err_len  out  1  sticky: header count > MAX_WORDS.
err_sum  out  1  sticky: checksum mismatch (feature only; tied 0 otherwise).
word_cnt  out  32  latched header word count.

Behaviour:
- Reset, asynchronous, active-low: state=S_LEN, all outputs 0, byte index 0, shift register 0, write pointer 0.
- States: S_LEN, S_DATA, S_SUM (feature only), S_DONE, S_ERR.
- Byte packing: a 2-bit byte index counts rx_valid strobes. Each byte shifts in from the LSB side (sh <= {sh[23:0], rx_data}), so the first byte lands in [31:24]. The index wraps 3->0.
- S_LEN: busy<=1 on the first byte. On the 4th byte, word_cnt <= packed value and the next state is decided:
  - count==0: go to S_DONE, or S_SUM when the feature is enabled.
  - count>MAX_WORDS: go to S_ERR and set err_len.
  - otherwise: go to S_DATA.
- S_DATA: on the 4th byte of each word, the next cycle shows imem_we=1, imem_wdata=packed word and imem_addr=BASE_ADDR+ptr; ptr then increments. Latency is 1 cycle from the final rx_valid to imem_we.
- After the word with ptr==word_cnt-1 is written: go to S_DONE (or S_SUM). done rises in the same cycle as that final imem_we, and busy falls in that cycle.
- imem_addr arithmetic is modulo 2**ADDR_W. Overflow cannot occur because MAX_WORDS is checked at the header.
- S_DONE/S_ERR: rx_valid is ignored and imem_we is never asserted. Flags hold until restart or reset.
- restart (any state): next cycle state=S_LEN with byte index, ptr, word_cnt, flags and busy cleared. restart beats a simultaneous rx_valid, and that byte is dropped.
- A restart or reset mid-word discards partial bytes. Words already written are not rolled back.
- Back-to-back rx_valid on consecutive cycles must be accepted; the block has no backpressure.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all payload bytes (not the header) is kept.
  - After the last word (or straight after a zero count), S_SUM waits for one extra byte.
  - On that byte, done<=1 one cycle later, and err_sum<=(byte != XOR).
- Undefined: S_SUM is absent, err_sum is constant 0, and done follows the last write as above.

Decomposition:
- Package loader_pkg holds:
  - typedef enum logic[2:0] loader_state_t {S_LEN,S_DATA,S_SUM,S_DONE,S_ERR}.
  - localparams WORD_W=32 and BYTES_PER_WORD=4.
- Sub-module byte_packer: byte index, shift register, word_ready pulse, clear input. It is reused for the header and payload words.
- The FSM, pointer and flags stay in uart_program_loader.

Test Plan:
- Bytes 00 00 00 02, DE AD BE EF, 01 02 03 04 -> writes (addr0, DEADBEEF) and (addr1, 01020304), one cycle after each 4th byte; done coincides with the second write.
- Header 00 00 00 00 -> no imem_we; done=1 one cycle after the 4th byte (feature off).
- Header above MAX_WORDS (ADDR_W=4, count 17) -> err_len=1, no writes, and further bytes are ignored.
- restart asserted on the same cycle as the 2nd payload byte of word 0 -> that byte is dropped; a fresh header 00 00 00 01 + 11 22 33 44 writes 11223344 at addr0.
- RST_N pulsed low asynchronously mid-payload -> outputs clear immediately without waiting for CLK.
- LOADER_CHECKSUM_EN with payload 01 02 03 04 followed by checksum byte 04 -> done=1, err_sum=0; a checksum byte of 05 -> done=1, err_sum=1.
